native2axi_master: RTL and testbench

- Bridge from a native register port to an AXI4-Lite master.
- Converts single-beat native read/write requests into complete AXI4-Lite transactions: AW+W+B for writes, AR+R for reads.
- Returns read data, a completion pulse and an error flag to the native requester.
- Used where a local controller must drive AXI-Lite peripherals that are normally register-mapped behind an AXI-to-native slave bridge.

---
 rtl/axi_lite_pkg.sv | 34 +++
 rtl/axi_valid_hold.sv | 34 +++
 rtl/native2axi_master.sv | 184 ++++++++++++++++++
 tb/tb_native2axi_master.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
//------------------------------------------------------------------------------
// Module   : axi_lite_pkg
// Brief    : Shared AXI4-Lite response codes, bridge FSM state type and
//            fixed protection value for the native-to-AXI master bridge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  // Anything other than OKAY is reported to the requester as an error
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_valid_hold.sv
//------------------------------------------------------------------------------
// Module   : axi_valid_hold
// Brief    : One AXI handshake source: raises valid on start, holds it until
//            the ready handshake, then drops it and flags the channel done.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_valid_hold (
  input  logic S_AXI_aclk,
  input  logic S_AXI_aresetn,
  input  logic start,
  input  logic ready,
  output logic valid,
  output logic done
);

  // Valid is only ever cleared by its own handshake, so it never retracts early
  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      valid <= 1'b1;
      done  <= 1'b0;
    end else if (valid && ready) begin
      valid <= 1'b0;
      done  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/native2axi_master.sv
//------------------------------------------------------------------------------
// Module   : native2axi_master
// Brief    : Native single-beat register port to AXI4-Lite master bridge.
//            Writes run AW+W+B, reads run AR+R; completion is a one-cycle
//            NATIVE_READY pulse with held read data and error flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module native2axi_master
  import axi_lite_pkg::*;
#(
  parameter int NATIVE_ADDR_WIDTH = 4,
  parameter int NATIVE_DATA_WIDTH = 32,
  parameter int M_AXI_ADDR_WIDTH  = 8,
  parameter int M_AXI_DATA_WIDTH  = 32
) (
  input  logic                          S_AXI_aclk,
  input  logic                          S_AXI_aresetn,
  input  logic                          NATIVE_EN,
  input  logic                          NATIVE_WR,
  input  logic [NATIVE_ADDR_WIDTH-1:0]  NATIVE_ADDR,
  input  logic [NATIVE_DATA_WIDTH-1:0]  NATIVE_DATA_IN,
  output logic [NATIVE_DATA_WIDTH-1:0]  NATIVE_DATA_OUT,
  output logic                          NATIVE_READY,
  output logic                          NATIVE_BUSY,
  output logic                          NATIVE_ERR,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]                    M_AXI_awprot,
  output logic                          M_AXI_awvalid,
  input  logic                          M_AXI_awready,
  output logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                          M_AXI_wvalid,
  input  logic                          M_AXI_wready,
  input  logic [1:0]                    M_AXI_bresp,
  input  logic                          M_AXI_bvalid,
  output logic                          M_AXI_bready,
  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]                    M_AXI_arprot,
  output logic                          M_AXI_arvalid,
  input  logic                          M_AXI_arready,
  input  logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]                    M_AXI_rresp,
  input  logic                          M_AXI_rvalid,
  output logic                          M_AXI_rready
);

  state_t                         r_state;
  logic [NATIVE_ADDR_WIDTH-1:0]   r_addr;
  logic [NATIVE_DATA_WIDTH-1:0]   r_wdata;
  logic [NATIVE_DATA_WIDTH-1:0]   r_data_out;
  logic                           r_ready;
  logic                           r_busy;
  logic                           r_err;
  logic                           r_bready;
  logic                           r_rready;

  logic w_start_wr;
  logic w_start_rd;
  logic w_aw_done;
  logic w_w_done;
  logic w_ar_done;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_ar_fin;

  // Requests are only taken in IDLE; EN while busy is silently dropped
  assign w_start_wr = (r_state == ST_IDLE) && NATIVE_EN && NATIVE_WR;
  assign w_start_rd = (r_state == ST_IDLE) && NATIVE_EN && !NATIVE_WR;

  axi_valid_hold u_aw_hold (
    .S_AXI_aclk    (S_AXI_aclk),
    .S_AXI_aresetn (S_AXI_aresetn),
    .start         (w_start_wr),
    .ready         (M_AXI_awready),
    .valid         (M_AXI_awvalid),
    .done          (w_aw_done)
  );

  axi_valid_hold u_w_hold (
    .S_AXI_aclk    (S_AXI_aclk),
    .S_AXI_aresetn (S_AXI_aresetn),
    .start         (w_start_wr),
    .ready         (M_AXI_wready),
    .valid         (M_AXI_wvalid),
    .done          (w_w_done)
  );

  axi_valid_hold u_ar_hold (
    .S_AXI_aclk    (S_AXI_aclk),
    .S_AXI_aresetn (S_AXI_aresetn),
    .start         (w_start_rd),
    .ready         (M_AXI_arready),
    .valid         (M_AXI_arvalid),
    .done          (w_ar_done)
  );

  // A channel counts as finished in the cycle of its handshake as well, so the
  // FSM advances without an extra bubble on a zero-wait slave
  assign w_aw_fin = w_aw_done || (M_AXI_awvalid && M_AXI_awready);
  assign w_w_fin  = w_w_done  || (M_AXI_wvalid  && M_AXI_wready);
  assign w_ar_fin = w_ar_done || (M_AXI_arvalid && M_AXI_arready);

  assign M_AXI_awaddr    = M_AXI_ADDR_WIDTH'({r_addr, 2'b00});
  assign M_AXI_araddr    = M_AXI_ADDR_WIDTH'({r_addr, 2'b00});
  assign M_AXI_awprot    = PROT_DEFAULT;
  assign M_AXI_arprot    = PROT_DEFAULT;
  assign M_AXI_wdata     = M_AXI_DATA_WIDTH'(r_wdata);
  assign M_AXI_wstrb     = '1;
  assign M_AXI_bready    = r_bready;
  assign M_AXI_rready    = r_rready;
  assign NATIVE_DATA_OUT = r_data_out;
  assign NATIVE_READY    = r_ready;
  assign NATIVE_BUSY     = r_busy;
  assign NATIVE_ERR      = r_err;

  // Transaction sequencer with all requester-facing outputs registered
  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_bready   <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (NATIVE_EN) begin
            r_addr  <= NATIVE_ADDR;
            r_wdata <= NATIVE_DATA_IN;
            r_busy  <= 1'b1;
            r_state <= NATIVE_WR ? ST_WR : ST_RD_ADDR;
          end
        end
        ST_WR: begin
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_bvalid && r_bready) begin
            r_bready <= 1'b0;
            r_err    <= resp_is_err(M_AXI_bresp);
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_fin) begin
            r_rready <= 1'b1;
            r_state  <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (M_AXI_rvalid && r_rready) begin
            r_rready   <= 1'b0;
            r_data_out <= M_AXI_rdata[NATIVE_DATA_WIDTH-1:0];
            r_err      <= resp_is_err(M_AXI_rresp);
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_bready <= 1'b0;
          r_rready <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_native2axi_master.sv
//------------------------------------------------------------------------------
// Module   : tb_native2axi_master
// Brief    : Randomised scoreboard bench for native2axi_master with a
//            behavioural AXI4-Lite slave and a requester-level reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_native2axi_master;

  localparam int NAW = 4;
  localparam int NDW = 32;
  localparam int MAW = 8;
  localparam int MDW = 32;

  logic           S_AXI_aclk = 1'b0;
  logic           S_AXI_aresetn = 1'b0;
  logic           NATIVE_EN = 1'b0;
  logic           NATIVE_WR = 1'b0;
  logic [NAW-1:0] NATIVE_ADDR = '0;
  logic [NDW-1:0] NATIVE_DATA_IN = '0;
  logic [NDW-1:0] NATIVE_DATA_OUT;
  logic           NATIVE_READY, NATIVE_BUSY, NATIVE_ERR;
  logic [MAW-1:0] M_AXI_awaddr, M_AXI_araddr;
  logic [2:0]     M_AXI_awprot, M_AXI_arprot;
  logic           M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready;
  logic [MDW-1:0] M_AXI_wdata;
  logic [MDW/8-1:0] M_AXI_wstrb;
  logic           M_AXI_awready = 1'b0, M_AXI_wready = 1'b0, M_AXI_arready = 1'b0;
  logic           M_AXI_bvalid = 1'b0, M_AXI_rvalid = 1'b0;
  logic [1:0]     M_AXI_bresp = 2'b00, M_AXI_rresp = 2'b00;
  logic [MDW-1:0] M_AXI_rdata = '0;

  native2axi_master #(
    .NATIVE_ADDR_WIDTH (NAW),
    .NATIVE_DATA_WIDTH (NDW),
    .M_AXI_ADDR_WIDTH  (MAW),
    .M_AXI_DATA_WIDTH  (MDW)
  ) dut (
    .S_AXI_aclk      (S_AXI_aclk),
    .S_AXI_aresetn   (S_AXI_aresetn),
    .NATIVE_EN       (NATIVE_EN),
    .NATIVE_WR       (NATIVE_WR),
    .NATIVE_ADDR     (NATIVE_ADDR),
    .NATIVE_DATA_IN  (NATIVE_DATA_IN),
    .NATIVE_DATA_OUT (NATIVE_DATA_OUT),
    .NATIVE_READY    (NATIVE_READY),
    .NATIVE_BUSY     (NATIVE_BUSY),
    .NATIVE_ERR      (NATIVE_ERR),
    .M_AXI_awaddr    (M_AXI_awaddr),
    .M_AXI_awprot    (M_AXI_awprot),
    .M_AXI_awvalid   (M_AXI_awvalid),
    .M_AXI_awready   (M_AXI_awready),
    .M_AXI_wdata     (M_AXI_wdata),
    .M_AXI_wstrb     (M_AXI_wstrb),
    .M_AXI_wvalid    (M_AXI_wvalid),
    .M_AXI_wready    (M_AXI_wready),
    .M_AXI_bresp     (M_AXI_bresp),
    .M_AXI_bvalid    (M_AXI_bvalid),
    .M_AXI_bready    (M_AXI_bready),
    .M_AXI_araddr    (M_AXI_araddr),
    .M_AXI_arprot    (M_AXI_arprot),
    .M_AXI_arvalid   (M_AXI_arvalid),
    .M_AXI_arready   (M_AXI_arready),
    .M_AXI_rdata     (M_AXI_rdata),
    .M_AXI_rresp     (M_AXI_rresp),
    .M_AXI_rvalid    (M_AXI_rvalid),
    .M_AXI_rready    (M_AXI_rready)
  );

  always #5 S_AXI_aclk = ~S_AXI_aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the requester should see at each completion
  typedef struct {
    logic [NDW-1:0] dout;
    logic           err;
  } exp_t;
  exp_t           exp_q[$];
  logic [NDW-1:0] model_dout = '0;

  // Slave configuration for the transaction in flight
  int             aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [1:0]     bresp_cfg, rresp_cfg;
  logic [MDW-1:0] rdata_cfg;
  logic [MAW-1:0] exp_addr;
  logic [MDW-1:0] exp_wdata;

  // Slave progress
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int aw_hs, w_hs, ar_hs;
  int aw_vcyc, w_vcyc;
  bit b_started, b_hs_next, r_started, r_hs_next;

  task automatic clear_slave();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; aw_vcyc = 0; w_vcyc = 0;
    b_started = 0; b_hs_next = 0; r_started = 0; r_hs_next = 0;
    M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_arready = 0;
    M_AXI_bvalid = 0; M_AXI_rvalid = 0;
  endtask

  // Behavioural AXI4-Lite slave; acts mid-cycle, its values are seen at the next rising edge
  initial begin
    forever begin
      @(negedge S_AXI_aclk);
      if (!S_AXI_aresetn) begin
        clear_slave();
      end else begin
        if (M_AXI_bready) check("bready_before_aw_w_done", (aw_hs > 0 && w_hs > 0), 1);
        if (M_AXI_rready) check("rready_before_ar_done", (ar_hs > 0), 1);
        // B: only offered after both AW and W handshakes are complete
        if (b_hs_next) begin
          M_AXI_bvalid = 0; b_hs_next = 0;
        end else begin
          if (!M_AXI_bvalid && aw_hs > 0 && w_hs > 0 && !b_started) begin
            if (b_cnt >= b_delay) begin
              M_AXI_bvalid = 1; M_AXI_bresp = bresp_cfg; b_started = 1;
            end else b_cnt++;
          end
          if (M_AXI_bvalid && M_AXI_bready) b_hs_next = 1;
        end
        // R: only offered after the AR handshake
        if (r_hs_next) begin
          M_AXI_rvalid = 0; r_hs_next = 0;
        end else begin
          if (!M_AXI_rvalid && ar_hs > 0 && !r_started) begin
            if (r_cnt >= r_delay) begin
              M_AXI_rvalid = 1; M_AXI_rresp = rresp_cfg; M_AXI_rdata = rdata_cfg; r_started = 1;
            end else r_cnt++;
          end
          if (M_AXI_rvalid && M_AXI_rready) r_hs_next = 1;
        end
        // AW
        if (M_AXI_awvalid) aw_vcyc++;
        if (M_AXI_awvalid && !M_AXI_awready) begin
          if (aw_cnt >= aw_delay) begin
            M_AXI_awready = 1; aw_hs++;
            check("awaddr", M_AXI_awaddr, exp_addr);
            check("awprot", M_AXI_awprot, 0);
          end else aw_cnt++;
        end else M_AXI_awready = 0;
        // W
        if (M_AXI_wvalid) w_vcyc++;
        if (M_AXI_wvalid && !M_AXI_wready) begin
          if (w_cnt >= w_delay) begin
            M_AXI_wready = 1; w_hs++;
            check("wdata", M_AXI_wdata, exp_wdata);
            check("wstrb", M_AXI_wstrb, 4'hF);
          end else w_cnt++;
        end else M_AXI_wready = 0;
        // AR
        if (M_AXI_arvalid && !M_AXI_arready) begin
          if (ar_cnt >= ar_delay) begin
            M_AXI_arready = 1; ar_hs++;
            check("araddr", M_AXI_araddr, exp_addr);
            check("arprot", M_AXI_arprot, 0);
          end else ar_cnt++;
        end else M_AXI_arready = 0;
      end
    end
  end

  // Monitor: every completion pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge S_AXI_aclk);
      if (S_AXI_aresetn && NATIVE_READY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", NATIVE_DATA_OUT, e.dout);
          check("err", NATIVE_ERR, e.err);
          check("busy_in_ready_cycle", NATIVE_BUSY, 0);
        end
      end
    end
  end

  // Issue one request and wait for its completion; called and returning at a falling edge
  task automatic do_txn(input bit wr, input logic [NAW-1:0] addr, input logic [NDW-1:0] data,
                        input int awd, input int wd, input int bd, input int ard, input int rd,
                        input logic [1:0] resp, input logic [MDW-1:0] rdat,
                        input bit poke, input bit chk_lat);
    int guard;
    int lat;
    exp_t e;
    guard = 0;
    while (NATIVE_BUSY && guard < 200) begin
      @(negedge S_AXI_aclk);
      guard++;
    end
    if (NATIVE_BUSY) check("busy_wait_timeout", 1, 0);
    clear_slave();
    aw_delay = awd; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
    bresp_cfg = resp; rresp_cfg = resp; rdata_cfg = rdat;
    exp_addr  = MAW'(addr) * 4;
    exp_wdata = MDW'(data);
    if (!wr) model_dout = rdat[NDW-1:0];
    e.dout = model_dout;
    e.err  = (resp != 2'b00);
    exp_q.push_back(e);
    NATIVE_EN = 1; NATIVE_WR = wr; NATIVE_ADDR = addr; NATIVE_DATA_IN = data;
    for (lat = 1; lat <= 300; lat++) begin
      @(negedge S_AXI_aclk);
      if (lat <= 2) begin
        NATIVE_EN = 0;
        NATIVE_ADDR = NAW'($urandom);
        NATIVE_DATA_IN = $urandom;
      end
      if (NATIVE_READY) break;
      if (poke && lat == 1) begin
        check("busy_during_txn", NATIVE_BUSY, 1);
        NATIVE_EN = 1; NATIVE_WR = $urandom_range(0, 1);
      end
    end
    if (!NATIVE_READY) check("ready_timeout", 0, 1);
    else if (chk_lat) check("latency", lat, 3);
    check("aw_handshakes", aw_hs, wr ? 1 : 0);
    check("w_handshakes", w_hs, wr ? 1 : 0);
    check("ar_handshakes", ar_hs, wr ? 0 : 1);
  endtask

  // Watchdog so the bench always ends on its own
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int guard;
    clear_slave();
    repeat (3) @(negedge S_AXI_aclk);
    check("reset_ready", NATIVE_READY, 0);
    check("reset_busy", NATIVE_BUSY, 0);
    check("reset_err", NATIVE_ERR, 0);
    check("reset_dout", NATIVE_DATA_OUT, 0);
    check("reset_valids", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready}, 0);
    check("reset_awaddr", M_AXI_awaddr, 0);
    S_AXI_aresetn = 1;
    @(negedge S_AXI_aclk);

    // Zero-wait write and read, then a write must leave read data intact
    do_txn(1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, '0, 0, 1);
    do_txn(0, 4'd5, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h12345678, 0, 1);
    do_txn(1, 4'd9, 32'hCAFEF00D, 0, 0, 0, 0, 0, 2'b00, '0, 0, 1);

    // Skewed AW/W in both orders and simultaneous
    do_txn(1, 4'd1, 32'h11111111, 4, 0, 0, 0, 0, 2'b00, '0, 0, 0);
    check("skew_aw_valid_cycles", aw_vcyc, 5);
    check("skew_w_valid_cycles", w_vcyc, 1);
    do_txn(1, 4'd2, 32'h22222222, 0, 4, 1, 0, 0, 2'b00, '0, 0, 0);
    check("skew2_aw_valid_cycles", aw_vcyc, 1);
    check("skew2_w_valid_cycles", w_vcyc, 5);
    do_txn(1, 4'd4, 32'h44444444, 2, 2, 0, 0, 0, 2'b00, '0, 0, 0);
    check("skew3_aw_valid_cycles", aw_vcyc, 3);
    check("skew3_w_valid_cycles", w_vcyc, 3);

    // Error response then OKAY clears it
    do_txn(1, 4'd6, 32'h66666666, 0, 0, 0, 0, 0, 2'b10, '0, 0, 1);
    do_txn(0, 4'd7, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5A5A5, 0, 1);

    // EN while busy must be ignored
    do_txn(1, 4'd8, 32'h88888888, 3, 2, 1, 0, 0, 2'b00, '0, 1, 0);
    do_txn(0, 4'd10, 32'h0, 0, 0, 0, 3, 2, 2'b00, 32'h0BADF00D, 1, 0);

    // Randomised back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] resp;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn($urandom_range(0, 1), NAW'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), resp, $urandom, 0, 0);
    end

    // Reset while waiting for read data
    clear_slave();
    ar_delay = 0; r_delay = 50; rresp_cfg = 2'b00; rdata_cfg = 32'h77777777;
    exp_addr = 8'h1C;
    NATIVE_EN = 1; NATIVE_WR = 0; NATIVE_ADDR = 4'd7;
    @(negedge S_AXI_aclk);
    NATIVE_EN = 0;
    guard = 0;
    while (!M_AXI_rready && guard < 50) begin
      @(negedge S_AXI_aclk);
      guard++;
    end
    check("reached_rd_data", M_AXI_rready, 1);
    S_AXI_aresetn = 0;
    #1;
    check("mid_reset_valids", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready}, 0);
    check("mid_reset_busy", NATIVE_BUSY, 0);
    check("mid_reset_ready", NATIVE_READY, 0);
    check("mid_reset_dout", NATIVE_DATA_OUT, 0);
    check("mid_reset_err", NATIVE_ERR, 0);
    model_dout = '0;
    repeat (2) @(negedge S_AXI_aclk);
    S_AXI_aresetn = 1;
    @(negedge S_AXI_aclk);
    do_txn(0, 4'd12, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h5EEDC0DE, 0, 1);

    repeat (5) @(negedge S_AXI_aclk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
